// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sync_fifo_pkg;

  // Read-interface mode names accepted by the FIFO_TYPE parameter
  localparam string FIFO_STANDARD = "Standard";
  localparam string FIFO_FWFT     = "FWFT";

  // Index width for n entries; never narrower than one bit
  function automatic int ptr_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_fifo_core_if.sv
// Push/pop handshake and data bus between the FIFO and its producer/consumer.
// Latency: n/a (wiring only).
// Backpressure: full/empty/valid flags travel on this bus.
interface sync_fifo_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rd_en;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  empty;
  logic                  full;
  logic                  valid;
  logic [DATA_WIDTH-1:0] dout;

  // Producer/consumer side
  modport master (output rd_en, output wr_en, output din,
                  input empty, input full, input valid, input dout);
  // FIFO side
  modport slave  (input rd_en, input wr_en, input din,
                  output empty, output full, output valid, output dout);
endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Latency: write visible on the read port after the write edge; read is combinational.
// Backpressure: none; the caller decides when a write is allowed.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store the incoming word; contents are intentionally never reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO with Standard (registered) or FWFT (fall-through) read port.
// Latency: Standard dout/valid 1 cycle after accepted read; FWFT head word shown 1 cycle after write, pop is 0-cycle.
// Backpressure: writes dropped while full, reads dropped while empty; flags come from registered count only.
module sync_fifo_core
  import sync_fifo_pkg::*;
#(
  parameter bit    SIM        = 1'b1,
  parameter int    DATA_WIDTH = 8,
  parameter int    FIFO_DEPTH = 10,
  parameter string FIFO_TYPE  = "Standard"
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_core_if.slave bus
);

  localparam int AW = ptr_width(FIFO_DEPTH);
  localparam int CW = ptr_width(FIFO_DEPTH + 1);

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_w, full_w;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] rd_data;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CW'(FIFO_DEPTH));
  assign wr_acc  = bus.wr_en && !full_w;
  assign rd_acc  = bus.rd_en && !empty_w;

  assign bus.empty = empty_w;
  assign bus.full  = full_w;

  // Next pointer/count values; pointers wrap at the last index, not at 2^AW
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .AW         (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  if (FIFO_TYPE == FIFO_STANDARD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;

    // Capture the head word on an accepted read; valid is a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) begin
          dout_q <= rd_data;
        end
      end
    end

    assign bus.dout  = dout_q;
    assign bus.valid = valid_q;
  end else if (FIFO_TYPE == FIFO_FWFT) begin : g_fwft
    // Head word is always on the bus; rd_en acknowledges and pops it
    assign bus.dout  = rd_data;
    assign bus.valid = !empty_w;
  end else begin : g_bad_type
    $fatal(1, "sync_fifo_core: FIFO_TYPE must be \"Standard\" or \"FWFT\"");
  end

  if (SIM) begin : g_sim
    // Report requests that are dropped because of the full/empty state
    always_ff @(posedge clk) begin
      if (rst_n && bus.wr_en && full_w) begin
        $error("sync_fifo_core: overflow, write ignored while full");
      end
      if (rst_n && bus.rd_en && empty_w) begin
        $error("sync_fifo_core: underflow, read ignored while empty");
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_core.sv
// Bench for sync_fifo_core: Standard and FWFT instances share one stimulus stream.
// Latency: checks taken on the falling edge after each stimulus edge.
// Backpressure: a queue model decides which requests are accepted.
module tb_sync_fifo_core;

  localparam int DEPTH = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en, rd_en;
  logic [7:0] din;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a plain queue plus what the Standard port should show
  logic [7:0] mq[$];
  logic [7:0] exp_std_dout;
  logic       exp_std_valid;

  always #5 clk = ~clk;

  sync_fifo_core_if #(.DATA_WIDTH(8)) if_std ();
  sync_fifo_core_if #(.DATA_WIDTH(8)) if_fw ();

  assign if_std.wr_en = wr_en;
  assign if_std.rd_en = rd_en;
  assign if_std.din   = din;
  assign if_fw.wr_en  = wr_en;
  assign if_fw.rd_en  = rd_en;
  assign if_fw.din    = din;

  sync_fifo_core #(.SIM(1'b0), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FIFO_TYPE("Standard"))
    dut_std (.clk(clk), .rst_n(rst_n), .bus(if_std));

  sync_fifo_core #(.SIM(1'b0), .DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FIFO_TYPE("FWFT"))
    dut_fw (.clk(clk), .rst_n(rst_n), .bus(if_fw));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the model
  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    chk({tag, ":std_empty"}, 32'(if_std.empty), 32'(sz == 0));
    chk({tag, ":std_full"},  32'(if_std.full),  32'(sz == DEPTH));
    chk({tag, ":std_valid"}, 32'(if_std.valid), 32'(exp_std_valid));
    chk({tag, ":std_dout"},  32'(if_std.dout),  32'(exp_std_dout));
    chk({tag, ":std_count"}, 32'(dut_std.count_q), 32'(sz));
    chk({tag, ":fw_empty"},  32'(if_fw.empty),  32'(sz == 0));
    chk({tag, ":fw_full"},   32'(if_fw.full),   32'(sz == DEPTH));
    chk({tag, ":fw_valid"},  32'(if_fw.valid),  32'(sz != 0));
    chk({tag, ":fw_count"},  32'(dut_fw.count_q), 32'(sz));
    if (sz != 0) chk({tag, ":fw_dout"}, 32'(if_fw.dout), 32'(mq[0]));
  endtask

  // One clock of stimulus, model update at the edge, check on the falling edge
  task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d);
    bit acc_w, acc_r;
    wr_en = w;
    rd_en = r;
    din   = d;
    @(posedge clk);
    acc_r = r && (mq.size() > 0);
    acc_w = w && (mq.size() < DEPTH);
    exp_std_valid = acc_r;
    if (acc_r) begin
      exp_std_dout = mq[0];
      void'(mq.pop_front());
    end
    if (acc_w) mq.push_back(d);
    @(negedge clk);
    check_all(tag);
  endtask

  // Asynchronous reset pulse of 20 ns, checked while asserted and after release
  task automatic do_reset(input string tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    rst_n = 1'b0;
    #1;
    mq.delete();
    exp_std_dout  = 8'h00;
    exp_std_valid = 1'b0;
    check_all({tag, "_in"});
    #19;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all({tag, "_out"});
  endtask

  initial begin
    logic [7:0] seq;

    do_reset("reset");

    // Fill with 0x01..0x0A, then one write that must be dropped
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 1'b0, 8'(i));
    step("overflow", 1'b1, 1'b0, 8'hFF);

    // Drain all ten; Standard shows each word one cycle after its read
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b1, 8'h00);
    step("idle", 1'b0, 1'b0, 8'h00);
    step("underflow", 1'b0, 1'b1, 8'h00);

    // FWFT presentation without rd_en, then pop
    step("fwft_wr", 1'b1, 1'b0, 8'h55);
    step("fwft_hold", 1'b0, 1'b0, 8'h00);
    step("fwft_pop", 1'b0, 1'b1, 8'h00);

    // Simultaneous push/pop when empty, then when full
    step("wr_rd_empty", 1'b1, 1'b1, 8'h31);
    for (int i = 0; i < DEPTH - 1; i++) step("refill", 1'b1, 1'b0, 8'(8'h40 + i));
    step("wr_rd_full", 1'b1, 1'b1, 8'hEE);
    while (mq.size() > 0) step("drain2", 1'b0, 1'b1, 8'h00);

    // Streaming through the wrap point with three words resident
    seq = 8'h80;
    for (int i = 0; i < 3; i++) begin
      step("prime", 1'b1, 1'b0, seq);
      seq++;
    end
    for (int i = 0; i < 25; i++) begin
      step("stream", 1'b1, 1'b1, seq);
      seq++;
    end
    while (mq.size() > 0) step("drain3", 1'b0, 1'b1, 8'h00);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step("random", 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50),
           8'($urandom_range(0, 255)));
    end

    // Reset with five words stored, then a fresh write/read
    while (mq.size() > 5) step("trim", 1'b0, 1'b1, 8'h00);
    while (mq.size() < 5) step("pad", 1'b1, 1'b0, 8'($urandom_range(0, 255)));
    do_reset("mid_reset");
    step("post_wr", 1'b1, 1'b0, 8'hA5);
    step("post_rd", 1'b0, 1'b1, 8'h00);
    step("post_idle", 1'b0, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
